// File: rtl/connector_pkg.sv
// Shared connector definitions: trace field widths, the per-block payload
// struct, itype codes that carry cause/tval, and the sequencer state type.
package connector_pkg;

    localparam int XLEN        = 32;
    localparam int PRIV_LEN    = 2;
    localparam int ITYPE_LEN   = 3;
    localparam int IRETIRE_LEN = 32;

    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

    typedef enum logic {IDLE, DRAIN} seq_state_e;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        iaddr;
    } te_block_s;

    // Exceptions and interrupts are the only blocks that carry cause/tval.
    function automatic logic has_payload(logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/te_block_sequencer_capture.sv
// te_group_capture: finds the contiguous run of valid lanes starting at
// lane 0. Lanes above the first gap are masked off and reported as
// malformed; cnt is the run length (0 when lane 0 itself is invalid).
module te_group_capture #(
    parameter int N  = 2,
    parameter int CW = $clog2(N) + 1
) (
    input  logic [N-1:0]  valid_i,
    output logic [N-1:0]  mask_o,
    output logic [CW-1:0] cnt_o,
    output logic          malformed_o
);

    logic run;

    // Thermometer prefix: a lane survives only if every lower lane is valid
    always_comb begin
        run         = 1'b1;
        mask_o      = '0;
        cnt_o       = '0;
        for (int k = 0; k < N; k++) begin
            run       = run & valid_i[k];
            mask_o[k] = run;
            cnt_o     = cnt_o + CW'(run);
        end
        malformed_o = |(valid_i & ~mask_o);
    end

endmodule

// File: rtl/te_block_sequencer.sv
// te_block_sequencer: latches a group of up to N trace blocks and replays
// them one per cycle, in lane order, over a valid/ready handshake.
// Optional feature macro: TE_SEQ_DROP_CNT_EN (saturating dropped-group
// counter on drop_cnt_o; tied to 0 when undefined).
module te_block_sequencer
    import connector_pkg::*;
#(
    parameter int N     = 2,
    parameter int CNT_W = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [N-1:0]                    valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_i,
    input  logic [N-1:0]                    ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]     itype_i,
    input  logic [N-1:0][XLEN-1:0]          iaddr_i,
    input  logic [XLEN-1:0]                 cause_i,
    input  logic [XLEN-1:0]                 tval_i,
    input  logic [PRIV_LEN-1:0]             priv_i,
    output logic                            ready_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [IRETIRE_LEN-1:0]          iretire_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [XLEN-1:0]                 iaddr_o,
    output logic [XLEN-1:0]                 cause_o,
    output logic [XLEN-1:0]                 tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic                            overflow_o,
    output logic                            malformed_o,
    output logic [CNT_W-1:0]                drop_cnt_o
);

    localparam int CW    = $clog2(N) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    seq_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CW-1:0]          cnt_q;
    te_block_s [N-1:0]      blk_q;
    logic [XLEN-1:0]        cause_q;
    logic [XLEN-1:0]        tval_q;
    logic [PRIV_LEN-1:0]    priv_q;
    logic                   overflow_q;
    logic                   malformed_q;

    logic [N-1:0]           mask_c;
    logic [CW-1:0]          cnt_c;
    logic                   mal_c;
    te_block_s [N-1:0]      lanes_c;
    te_block_s              cur;
    logic                   offer;
    logic                   last;
    logic                   accept;
    logic                   capture;
    logic                   ovf_ev;

    te_group_capture #(.N(N), .CW(CW)) u_capture (
        .valid_i     (valid_i),
        .mask_o      (mask_c),
        .cnt_o       (cnt_c),
        .malformed_o (mal_c)
    );

    // Gather the per-lane input fields into block structs
    always_comb begin
        lanes_c = '0;
        for (int k = 0; k < N; k++) begin
            lanes_c[k].iretire   = iretire_i[k];
            lanes_c[k].ilastsize = ilastsize_i[k];
            lanes_c[k].itype     = itype_i[k];
            lanes_c[k].iaddr     = iaddr_i[k];
        end
    end

    assign offer   = |valid_i;
    assign last    = (state_q == DRAIN) && (CW'(idx_q) == cnt_q - CW'(1));
    assign ready_o = (state_q == IDLE) || (last && ready_i);
    // Flush outranks any same-cycle offer: neither captured nor an overflow.
    assign accept  = offer && ready_o && !flush_i;
    assign capture = accept && (cnt_c != '0);
    assign ovf_ev  = offer && !ready_o && !flush_i;

    // Group FSM: capture (including back-to-back reload), lane-order drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            priv_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (capture) begin
            for (int k = 0; k < N; k++)
                blk_q[k] <= mask_c[k] ? lanes_c[k] : '0;
            cnt_q   <= cnt_c;
            cause_q <= cause_i;
            tval_q  <= tval_i;
            priv_q  <= priv_i;
            idx_q   <= '0;
            state_q <= DRAIN;
        end else if (state_q == DRAIN && ready_i) begin
            if (last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            malformed_q <= 1'b0;
        end else begin
            if (ovf_ev)
                overflow_q  <= 1'b1;
            if (accept && mal_c)
                malformed_q <= 1'b1;
        end
    end

`ifdef TE_SEQ_DROP_CNT_EN
    logic [CNT_W-1:0] drop_q;

    // Saturating count of groups lost to overflow
    always_ff @(posedge clk_i) begin
        if (rst_i)
            drop_q <= '0;
        else if (ovf_ev && (drop_q != '1))
            drop_q <= drop_q + CNT_W'(1);
    end

    assign drop_cnt_o = drop_q;
`else
    assign drop_cnt_o = '0;
`endif

    // Outputs are a mux off flops only, so they hold while stalled
    assign cur         = blk_q[idx_q];
    assign valid_o     = (state_q == DRAIN);
    assign iretire_o   = valid_o ? cur.iretire   : '0;
    assign ilastsize_o = valid_o ? cur.ilastsize : 1'b0;
    assign itype_o     = valid_o ? cur.itype     : '0;
    assign iaddr_o     = valid_o ? cur.iaddr     : '0;
    assign cause_o     = (valid_o && has_payload(cur.itype)) ? cause_q : '0;
    assign tval_o      = (valid_o && has_payload(cur.itype)) ? tval_q  : '0;
    assign priv_o      = valid_o ? priv_q : '0;
    assign overflow_o  = overflow_q;
    assign malformed_o = malformed_q;

endmodule

// File: tb/tb_te_block_sequencer.sv
// Testbench for te_block_sequencer (N=2, CNT_W=2): directed table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_te_block_sequencer;
    import connector_pkg::*;

    localparam int N     = 2;
    localparam int CNT_W = 2;

    logic                          clk_i = 1'b0;
    logic                          rst_i, flush_i, ready_i;
    logic [N-1:0]                  valid_i;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]                  ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
    logic [N-1:0][XLEN-1:0]        iaddr_i;
    logic [XLEN-1:0]               cause_i, tval_i;
    logic [PRIV_LEN-1:0]           priv_i;
    logic                          ready_o, valid_o, ilastsize_o;
    logic [IRETIRE_LEN-1:0]        iretire_o;
    logic [ITYPE_LEN-1:0]          itype_o;
    logic [XLEN-1:0]               iaddr_o, cause_o, tval_o;
    logic [PRIV_LEN-1:0]           priv_o;
    logic                          overflow_o, malformed_o;
    logic [CNT_W-1:0]              drop_cnt_o;

    te_block_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
        .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .overflow_o(overflow_o), .malformed_o(malformed_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef TE_SEQ_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model: queue of blocks still to be emitted
    typedef struct packed {
        logic [31:0] iretire;
        logic        ilastsize;
        logic [2:0]  itype;
        logic [31:0] iaddr;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [1:0]  priv;
    } exp_t;

    exp_t q[$];
    bit   model_ok = 0;
    bit   m_ovf = 0, m_mal = 0;
    int   m_drop = 0;

    task automatic model_check();
        exp_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("valid_o",     valid_o, q.size() != 0);
        chk("ready_o",     ready_o, (q.size() == 0) || (q.size() == 1 && ready_i));
        chk("iaddr_o",     iaddr_o, h.iaddr);
        chk("iretire_o",   iretire_o, h.iretire);
        chk("ilastsize_o", ilastsize_o, h.ilastsize);
        chk("itype_o",     itype_o, h.itype);
        chk("cause_o",     cause_o, h.cause);
        chk("tval_o",      tval_o, h.tval);
        chk("priv_o",      priv_o, h.priv);
        chk("overflow_o",  overflow_o, m_ovf);
        chk("malformed_o", malformed_o, m_mal);
        chk("drop_cnt_o",  drop_cnt_o, m_drop);
    endtask

    task automatic model_update();
        bit   rdy;
        int   len;
        exp_t e;
        if (rst_i) begin
            q.delete(); m_ovf = 0; m_mal = 0; m_drop = 0; model_ok = 1;
        end else if (flush_i) begin
            q.delete();
        end else begin
            rdy = (q.size() == 0) || (q.size() == 1 && ready_i);
            if (q.size() != 0 && ready_i) void'(q.pop_front());
            if (valid_i != 0) begin
                if (!rdy) begin
                    m_ovf = 1;
                    if (DROP_EN != 0 && m_drop < (1 << CNT_W) - 1) m_drop++;
                end else begin
                    len = 0;
                    while (len < N && valid_i[len]) len++;
                    for (int k = len; k < N; k++) if (valid_i[k]) m_mal = 1;
                    for (int k = 0; k < len; k++) begin
                        e.iretire   = iretire_i[k];
                        e.ilastsize = ilastsize_i[k];
                        e.itype     = itype_i[k];
                        e.iaddr     = iaddr_i[k];
                        e.cause     = (itype_i[k] == 1 || itype_i[k] == 2) ? cause_i : 32'h0;
                        e.tval      = (itype_i[k] == 1 || itype_i[k] == 2) ? tval_i  : 32'h0;
                        e.priv      = priv_i;
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    // One clock: inputs are set at the negedge, checked 1 unit later.
    task automatic tick();
        #1;
        if (model_ok && !rst_i) model_check();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic set_group(logic [1:0] v, logic [31:0] a0, logic [31:0] a1,
                             logic [2:0] t0, logic [2:0] t1,
                             logic [31:0] c, logic [31:0] tv, logic [1:0] p);
        valid_i     = v;
        iaddr_i[0]  = a0;          iaddr_i[1]  = a1;
        iretire_i[0]= a0 ^ 32'h5;  iretire_i[1]= a1 ^ 32'h9;
        ilastsize_i = 2'b10;
        itype_i[0]  = t0;          itype_i[1]  = t1;
        cause_i     = c;           tval_i      = tv;   priv_i = p;
    endtask

    task automatic do_reset();
        rst_i = 1; flush_i = 0; valid_i = '0; ready_i = 1;
        tick();
        rst_i = 0;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [2:0]  t0, t1;
        int          nblk;
        logic        mal;
        logic [31:0] c0;
    } vec_t;

    vec_t tbl[6];
    int   cnt;
    logic [31:0] first_cause;

    initial begin
        rst_i = 1; flush_i = 0; ready_i = 1; valid_i = '0;
        set_group(2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);

        // ---- reset state
        do_reset();
        chk("rst valid_o", valid_o, 0);
        chk("rst ready_o", ready_o, 1);
        chk("rst iaddr_o", iaddr_o, 0);
        chk("rst cause_o", cause_o, 0);
        chk("rst flags", {overflow_o, malformed_o}, 0);
        chk("rst drop_cnt_o", drop_cnt_o, 0);

        // ---- table-driven single-group offers from IDLE
        tbl[0] = '{2'b11, 3'd0, 3'd0, 2, 1'b0, 32'h0};
        tbl[1] = '{2'b01, 3'd0, 3'd0, 1, 1'b0, 32'h0};
        tbl[2] = '{2'b10, 3'd0, 3'd0, 0, 1'b1, 32'h0};
        tbl[3] = '{2'b00, 3'd0, 3'd0, 0, 1'b0, 32'h0};
        tbl[4] = '{2'b11, 3'd2, 3'd1, 2, 1'b0, 32'hC000_0005};
        tbl[5] = '{2'b01, 3'd1, 3'd0, 1, 1'b0, 32'hC000_0005};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_group(tbl[i].v, 32'h100 + i, 32'h200 + i, tbl[i].t0, tbl[i].t1,
                      32'hC000_0005, 32'h77, 2'd1);
            tick();
            valid_i = '0;
            cnt = 0; first_cause = 0;
            for (int c = 0; c < 4; c++) begin
                if (valid_o) begin
                    if (cnt == 0) first_cause = cause_o;
                    cnt++;
                end
                tick();
            end
            chk($sformatf("tbl%0d blocks", i), cnt, tbl[i].nblk);
            chk($sformatf("tbl%0d malformed", i), malformed_o, tbl[i].mal);
            chk($sformatf("tbl%0d cause", i), first_cause, tbl[i].c0);
        end

        // ---- basic drain: lane0 then lane1 then idle
        do_reset();
        set_group(2'b11, 32'h1000, 32'h2000, 0, 0, 0, 0, 2'd3);
        tick(); valid_i = '0;
        chk("basic b0 valid", valid_o, 1); chk("basic b0 iaddr", iaddr_o, 32'h1000);
        tick();
        chk("basic b1 valid", valid_o, 1); chk("basic b1 iaddr", iaddr_o, 32'h2000);
        tick();
        chk("basic idle valid", valid_o, 0); chk("basic idle ready", ready_o, 1);

        // ---- stall: lane0 held 4 cycles
        set_group(2'b11, 32'h3000, 32'h4000, 0, 0, 0, 0, 2'd1);
        ready_i = 0;
        tick(); valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            chk("stall hold iaddr", iaddr_o, 32'h3000);
            tick();
        end
        ready_i = 1;
        chk("stall 4th iaddr", iaddr_o, 32'h3000);
        tick();
        chk("stall lane1 iaddr", iaddr_o, 32'h4000);
        tick();
        chk("stall idle", valid_o, 0);
        chk("stall no overflow", overflow_o, 0);

        // ---- back-to-back, then an offer one cycle early
        set_group(2'b11, 32'h5000, 32'h6000, 0, 0, 0, 0, 2'd0);
        tick(); valid_i = '0;
        tick();
        set_group(2'b11, 32'h7000, 32'h8000, 0, 0, 0, 0, 2'd0);
        #1 chk("b2b ready on last beat", ready_o, 1);
        tick(); valid_i = '0;
        chk("b2b no bubble valid", valid_o, 1);
        chk("b2b no bubble iaddr", iaddr_o, 32'h7000);
        set_group(2'b11, 32'h9000, 32'hA000, 0, 0, 0, 0, 2'd0);
        #1 chk("early ready_o", ready_o, 0);
        tick(); valid_i = '0;
        chk("early overflow", overflow_o, 1);
        chk("early drop_cnt", drop_cnt_o, DROP_EN);
        chk("early lane1", iaddr_o, 32'h8000);
        tick();
        chk("early dropped", valid_o, 0);

        // ---- malformed and cause/tval gating
        do_reset();
        set_group(2'b10, 32'hAA, 32'hBB, 0, 0, 0, 0, 0);
        tick(); valid_i = '0;
        chk("mal nothing", valid_o, 0);
        chk("mal flag", malformed_o, 1);
        set_group(2'b11, 32'hB000, 32'hC000, 3'd1, 3'd0, 32'h8000_0007, 32'h1234, 2'd3);
        tick(); valid_i = '0;
        chk("exc lane0 cause", cause_o, 32'h8000_0007);
        chk("exc lane0 tval", tval_o, 32'h1234);
        chk("exc lane0 priv", priv_o, 3);
        tick();
        chk("exc lane1 cause", cause_o, 0);
        chk("exc lane1 priv", priv_o, 3);
        tick();

        // ---- flush mid-drain; flush beats a same-cycle offer
        do_reset();
        set_group(2'b11, 32'hD000, 32'hE000, 0, 0, 0, 0, 0);
        ready_i = 0;
        tick(); valid_i = '0;
        chk("flush pre lane0", iaddr_o, 32'hD000);
        ready_i = 1; flush_i = 1;
        tick(); flush_i = 0;
        chk("flush valid", valid_o, 0);
        #1 chk("flush ready", ready_o, 1);
        tick();
        chk("flush no lane1", valid_o, 0);
        set_group(2'b11, 32'h1, 32'h2, 0, 0, 0, 0, 0); flush_i = 1;
        tick(); valid_i = '0; flush_i = 0;
        chk("flush+offer no capture", valid_o, 0);
        chk("flush+offer no overflow", overflow_o, 0);

        // ---- reset mid-drain clears flags
        set_group(2'b11, 32'hF000, 32'hF100, 0, 0, 0, 0, 0);
        ready_i = 0;
        tick();
        tick(); valid_i = '0;
        chk("pre-rst overflow", overflow_o, 1);
        rst_i = 1;
        tick(); rst_i = 0;
        chk("mid rst valid", valid_o, 0);
        chk("mid rst flags", {overflow_o, malformed_o}, 0);
        #1 chk("mid rst ready", ready_o, 1);
        ready_i = 1;
        tick();
        chk("mid rst no remainder", valid_o, 0);

        // ---- five overflows: counter saturates at 3 when enabled
        do_reset();
        set_group(2'b11, 32'h11, 32'h22, 0, 0, 0, 0, 0);
        ready_i = 0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        valid_i = '0;
        chk("sat drop_cnt", drop_cnt_o, DROP_EN * 3);
        tick();
        chk("sat drop_cnt hold", drop_cnt_o, DROP_EN * 3);
        ready_i = 1;
        tick(); tick(); tick();

        // ---- randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            rst_i   = ($urandom_range(0, 199) == 0);
            flush_i = ($urandom_range(0, 19) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            set_group(($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3)),
                      $urandom, $urandom, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                      $urandom, $urandom, 2'($urandom_range(0, 3)));
            ilastsize_i = 2'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/te_block_sequencer.md
Name: te_block_sequencer

Overview:
- Sits between the CVA6 connector and a single-lane trace encoder input.
- Accepts a group of up to N parallel blocks in one cycle (valid/iretire/ilastsize/itype/iaddr per lane, plus shared cause/tval/priv) and registers the group.
- Emits the blocks one per cycle, in lane order, over a valid/ready handshake.
- Tells upstream when it can take the next group, and flags lost or malformed groups.

Parameters:
- N, 2, max blocks per input group (lanes); must be >= 1.
- CNT_W, 16, width of the saturating dropped-group counter (present only with the optional feature).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous flush; discards the buffered group.
- valid_i  in  N  per-lane block valid; lanes must be contiguous from lane 0.
- iretire_i  in  N x IRETIRE_LEN  per-lane retired halfword count.
- ilastsize_i  in  N  per-lane last instruction size.
- itype_i  in  N x ITYPE_LEN  per-lane itype.
- iaddr_i  in  N x XLEN  per-lane address.
- cause_i  in  XLEN  group exception/interrupt cause.
- tval_i  in  XLEN  group tval.
- priv_i  in  PRIV_LEN  group privilege.
- ready_o  out  1  sequencer can capture a group this cycle.
- valid_o  out  1  output block valid.
- ready_i  in  1  encoder accepts the output block.
- iretire_o / ilastsize_o / itype_o / iaddr_o  out  IRETIRE_LEN / 1 / ITYPE_LEN / XLEN  current block.
- cause_o, tval_o  out  XLEN each  nonzero only for an itype 1 or 2 block.
- priv_o  out  PRIV_LEN  priv of the current group.
- overflow_o  out  1  sticky: a group was offered while ready_o = 0.
- malformed_o  out  1  sticky: non-contiguous valid_i was seen.
- drop_cnt_o  out  CNT_W  dropped-group count (optional feature only).

Behaviour:
- Reset (rst_i = 1, sampled at clk edge):
  - state = IDLE; buffer, idx and cnt cleared.
  - valid_o = 0; all data outputs = 0; overflow_o = 0; malformed_o = 0; drop_cnt_o = 0.
  - ready_o = 1 from the first cycle after reset.
  - A reset mid-drain discards the group without emitting the remaining blocks.
- Group offer = |valid_i.
- Capture:
  - Lane k is kept only if valid_i[0..k] are all 1.
  - cnt = length of that prefix, range 1..N; width $clog2(N)+1.
  - If the offer is accepted and valid_i is not a thermometer code (a valid bit above the first 0), malformed_o sets.
  - If valid_i[0] = 0 while an offer exists, cnt = 0: nothing is captured, malformed_o sets, state is unchanged.
  - If the group offer is present but ready_o = 0: group is dropped and overflow_o sets.
- ready_o (combinational) = (state == IDLE) || (state == DRAIN && ready_i && idx == cnt-1).
- FSM:
  - IDLE: valid_o = 0. On a valid capture -> DRAIN with idx = 0. Latency from group offer to first valid_o is 1 cycle.
  - DRAIN: valid_o = 1; outputs = buf[idx].
    - On ready_i with idx < cnt-1: idx++.
    - On ready_i with idx == cnt-1 and a valid capture the same cycle: reload the buffer, idx = 0, stay in DRAIN (back-to-back, no bubble).
    - On ready_i with idx == cnt-1 and no capture: -> IDLE.
- Output stability: while valid_o && !ready_i, all outputs hold.
- cause_o/tval_o: buf cause/tval when itype_o is 1 or 2, else 0. priv_o = the group's latched priv.
- flush_i: state -> IDLE, valid_o = 0 the next cycle, buffer contents ignored.
  - flush_i in the same cycle as a group offer: flush wins, the offer is not captured and not counted as overflow.
- Sticky flags clear only on rst_i.
- N = 1: idx is a constant 0; every accepted group yields exactly one block.

Optional Feature:
- Macro: TE_SEQ_DROP_CNT_EN.
- Defined: drop_cnt_o increments by 1 on every overflow drop and saturates at all-ones (no wrap). Reset to 0.
- Undefined: drop_cnt_o is tied to 0; no counter flops.
- overflow_o is present in both cases.

Decomposition:
- Shared package connector_pkg: XLEN, PRIV_LEN, ITYPE_LEN, IRETIRE_LEN.
- Add to connector_pkg:
  - te_block_s struct (iretire, ilastsize, itype, iaddr).
  - ITYPE_EXC = 1 and ITYPE_INT = 2 constants.
  - seq_state_e enum {IDLE, DRAIN}.
- One sub-module, te_group_capture: combinational thermometer-prefix length and malformed detect, producing cnt and a clean valid mask.

Test Plan:
- N=2, valid_i = 2'b11 in IDLE, ready_i = 1 -> valid_o high for 2 consecutive cycles starting 1 cycle later, lane0 block then lane1 block; returns to IDLE.
- Group of 2 offered, ready_i low for 3 cycles then high -> lane0 block held stable for 4 cycles, then lane1 block; no overflow_o.
- Second group offered on the cycle the last block of the first group handshakes -> ready_o = 1, no bubble between groups; group offered one cycle earlier -> overflow_o = 1 and, with TE_SEQ_DROP_CNT_EN, drop_cnt_o = 1.
- valid_i = 2'b10 -> nothing emitted, malformed_o = 1; valid_i = 2'b11 with lane0 itype = 1, cause_i = 32'h8000_0007 -> cause_o = 32'h8000_0007 on lane0 block only, 0 on lane1 block.
- flush_i, or rst_i, asserted mid-drain with 1 block remaining -> valid_o = 0 next cycle, ready_o = 1, remaining block never emitted; with rst_i, sticky flags also clear.
- With TE_SEQ_DROP_CNT_EN and CNT_W = 2, cause 5 overflows -> drop_cnt_o reads 3 and holds.
